burst_ctrl: RTL and testbench

- Interrupter/burst sequencer for the DRSSTC drive path.
- Turns an external interrupter request into bounded bridge-enable bursts:
  - starts and stops each burst on a generator half-cycle boundary;
  - enforces a maximum on-time and a minimum off-time;
  - forces the bridge off on overcurrent.
- Sits upstream of the gen/fb selector: drive output = selector output AND `en`.

---
 rtl/burst_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_burst_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/burst_ctrl.sv
// burst_ctrl -- interrupter/burst sequencer for the DRSSTC drive path.
//
// Converts an interrupter request into bounded bridge-enable bursts. Each
// burst starts and stops on a generator falling edge, or after a short
// alignment timeout if gen is absent. On-time is capped and a minimum
// off-time follows each burst. Overcurrent forces the bridge off at once.
// Downstream, the drive output is the gen/fb selector output ANDed with en.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous, active-high reset
//   trig   in   interrupter request (pre-synced); a rising edge starts a
//               burst and the high level sustains it
//   gen    in   generator square wave (pre-synced)
//   ocd    in   overcurrent comparator (pre-synced), active-high
//   en     out  bridge enable (registered)
//   busy   out  high in START/BURST/STOP/HOLDOFF (registered)
//   fault  out  high in FAULT (registered)
//
// Build option:
//   OCD_LATCH_EN  when defined, FAULT is left only through rst. When it is
//                 not defined, FAULT self-clears after COOLDOWN_US of
//                 continuous ocd=0.
module burst_ctrl #(
  parameter int unsigned CLK_MHZ          = 100,
  parameter int unsigned ON_MAX_US        = 200,
  parameter int unsigned OFF_MIN_US       = 2000,
  parameter int unsigned ALIGN_TIMEOUT_US = 4,
  parameter int unsigned COOLDOWN_US      = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  input  logic gen,
  input  logic ocd,
  output logic en,
  output logic busy,
  output logic fault
);

  localparam int unsigned ON_MAX_CYC   = CLK_MHZ * ON_MAX_US;
  localparam int unsigned OFF_MIN_CYC  = CLK_MHZ * OFF_MIN_US;
  localparam int unsigned ALIGN_CYC    = CLK_MHZ * ALIGN_TIMEOUT_US;

  localparam int unsigned ON_W  = $clog2(ON_MAX_CYC + 1);
  localparam int unsigned OFF_W = $clog2(OFF_MIN_CYC + 1);
  localparam int unsigned AL_W  = $clog2(ALIGN_CYC + 1);

  localparam logic [ON_W-1:0]  ON_LAST  = ON_W'(ON_MAX_CYC - 1);
  localparam logic [OFF_W-1:0] OFF_LOAD = OFF_W'(OFF_MIN_CYC - 1);
  localparam logic [AL_W-1:0]  AL_LOAD  = AL_W'(ALIGN_CYC - 1);

`ifndef OCD_LATCH_EN
  localparam int unsigned COOLDOWN_CYC = CLK_MHZ * COOLDOWN_US;
  localparam int unsigned CL_W         = $clog2(COOLDOWN_CYC + 1);
  localparam logic [CL_W-1:0] CL_LOAD  = CL_W'(COOLDOWN_CYC - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BURST, S_STOP, S_HOLDOFF, S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [ON_W-1:0]  on_cnt_q, on_cnt_d;
  logic [OFF_W-1:0] off_cnt_q, off_cnt_d;
  logic [AL_W-1:0]  align_cnt_q, align_cnt_d;
`ifndef OCD_LATCH_EN
  logic [CL_W-1:0]  cool_cnt_q, cool_cnt_d;
`endif
  logic             en_q, en_d, busy_q, busy_d, fault_q, fault_d;

  // One-cycle-delayed copies for edge detection. trig_prev resets to 1 so
  // that a trig already high at reset release does not count as an edge.
  logic trig_prev_q, gen_prev_q;
  logic trig_re, gen_fe;

  assign trig_re = trig & ~trig_prev_q;
  assign gen_fe  = gen_prev_q & ~gen;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      on_cnt_q    <= '0;
      off_cnt_q   <= '0;
      align_cnt_q <= '0;
`ifndef OCD_LATCH_EN
      cool_cnt_q  <= '0;
`endif
      trig_prev_q <= 1'b1;
      gen_prev_q  <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      on_cnt_q    <= on_cnt_d;
      off_cnt_q   <= off_cnt_d;
      align_cnt_q <= align_cnt_d;
`ifndef OCD_LATCH_EN
      cool_cnt_q  <= cool_cnt_d;
`endif
      trig_prev_q <= trig;
      gen_prev_q  <= gen;
      en_q        <= en_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state and counter logic. Down-counters saturate at zero.
  always_comb begin
    state_d     = state_q;
    on_cnt_d    = on_cnt_q;
    off_cnt_d   = off_cnt_q;
    align_cnt_d = align_cnt_q;
`ifndef OCD_LATCH_EN
    cool_cnt_d  = cool_cnt_q;
`endif
    if (ocd && state_q != S_FAULT) begin
      // Overcurrent cuts the bridge immediately, with no gen alignment
      state_d = S_FAULT;
`ifndef OCD_LATCH_EN
      cool_cnt_d = CL_LOAD;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: if (trig_re) begin
          state_d     = S_START;
          align_cnt_d = AL_LOAD;
        end
        S_START: begin
          align_cnt_d = (align_cnt_q != '0) ? align_cnt_q - 1'b1 : '0;
          if (gen_fe || align_cnt_q == '0) begin
            state_d  = S_BURST;
            on_cnt_d = '0;
          end
        end
        S_BURST: begin
          on_cnt_d = on_cnt_q + 1'b1;
          if (!trig || on_cnt_q == ON_LAST) begin
            state_d     = S_STOP;
            align_cnt_d = AL_LOAD;
          end
        end
        S_STOP: begin
          align_cnt_d = (align_cnt_q != '0) ? align_cnt_q - 1'b1 : '0;
          if (gen_fe || align_cnt_q == '0) begin
            state_d   = S_HOLDOFF;
            off_cnt_d = OFF_LOAD;
          end
        end
        S_HOLDOFF: begin
          off_cnt_d = (off_cnt_q != '0) ? off_cnt_q - 1'b1 : '0;
          if (off_cnt_q == '0) state_d = S_IDLE;
        end
        S_FAULT: begin
`ifndef OCD_LATCH_EN
          // Cooldown restarts on every cycle that ocd is still asserted
          if (ocd)                    cool_cnt_d = CL_LOAD;
          else if (cool_cnt_q == '0)  state_d    = S_IDLE;
          else                        cool_cnt_d = cool_cnt_q - 1'b1;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decode the next state so they switch on the same edge as state
  always_comb begin
    en_d    = (state_d == S_BURST) || (state_d == S_STOP);
    busy_d  = (state_d == S_START) || (state_d == S_BURST) ||
              (state_d == S_STOP)  || (state_d == S_HOLDOFF);
    fault_d = (state_d == S_FAULT);
  end

  assign en    = en_q;
  assign busy  = busy_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_burst_ctrl.sv
// Self-checking bench for burst_ctrl. A deadline-based behavioural model
// predicts en/busy/fault on every cycle. Directed scenarios add literal
// timing checks, and a randomized phase follows.
module tb_burst_ctrl;
  localparam int ALIGN = 10, ONMAX = 50, OFFMIN = 100, COOL = 200;

  logic clk = 1'b0, rst = 1'b1, trig = 1'b0, gen = 1'b0, ocd = 1'b0;
  logic en, busy, fault;

  burst_ctrl #(.CLK_MHZ(10), .ON_MAX_US(5), .OFF_MIN_US(10),
               .ALIGN_TIMEOUT_US(1), .COOLDOWN_US(20)) dut (
    .clk(clk), .rst(rst), .trig(trig), .gen(gen), .ocd(ocd),
    .en(en), .busy(busy), .fault(fault));

  always #5 clk = ~clk;

  // Generator: period 8 cycles, or held at 0 when gen_on is cleared
  logic gen_on = 1'b1;
  int   gph = 0;
  always @(negedge clk) begin
    gph <= (gph + 1) % 8;
    gen <= gen_on ? (gph < 4) : 1'b0;
  end

  int n_chk = 0, n_fail = 0, cyc = 0;

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", nm, act, lo, hi, cyc);
    end
  endtask

  // Behavioural model: a mode plus the absolute cycle at which it began
  typedef enum {M_IDLE, M_ALIGN_ON, M_ON, M_ALIGN_OFF, M_REST, M_TRIP} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_t0 = 0, m_last_ocd = 0;
  logic  m_trig_prev = 1'b1, m_gen_prev = 1'b0, seeded = 1'b0;

  // Observations of the DUT outputs, used by the directed checks
  logic en_prev = 1'b0, busy_prev = 1'b0, fault_prev = 1'b0;
  int   en_rise = 0, en_fall = 0, busy_rise = 0, fault_rise = 0, fault_fall = 0;
  int   n_bursts = 0, ocd_first = 0, ocd_last = 0;
  logic fe_at_rise = 1'b0, fe_at_fall = 1'b0, ocd_prev_s = 1'b0;

  always begin
    logic fe, re;
    @(posedge clk);
    #1;
    cyc++;
    fe = m_gen_prev & ~gen;
    re = trig & ~m_trig_prev;
    if (rst) begin
      m_mode = M_IDLE;
      seeded = 1'b1;
    end else if (ocd && m_mode != M_TRIP) begin
      m_mode = M_TRIP;
      m_last_ocd = cyc;
    end else begin
      case (m_mode)
        M_IDLE:      if (re) begin m_mode = M_ALIGN_ON; m_t0 = cyc; end
        M_ALIGN_ON:  if (fe || cyc >= m_t0 + ALIGN) begin m_mode = M_ON; m_t0 = cyc; end
        M_ON:        if (!trig || cyc >= m_t0 + ONMAX) begin m_mode = M_ALIGN_OFF; m_t0 = cyc; end
        M_ALIGN_OFF: if (fe || cyc >= m_t0 + ALIGN) begin m_mode = M_REST; m_t0 = cyc; end
        M_REST:      if (cyc >= m_t0 + OFFMIN) m_mode = M_IDLE;
        M_TRIP: begin
`ifndef OCD_LATCH_EN
          if (ocd) m_last_ocd = cyc;
          else if (cyc >= m_last_ocd + COOL) m_mode = M_IDLE;
`endif
        end
        default: m_mode = M_IDLE;
      endcase
    end
    m_trig_prev = rst ? 1'b1 : trig;
    m_gen_prev  = rst ? 1'b0 : gen;

    if (seeded) begin
      chk_bit("en",    en,    m_mode == M_ON || m_mode == M_ALIGN_OFF);
      chk_bit("busy",  busy,  m_mode == M_ALIGN_ON || m_mode == M_ON ||
                              m_mode == M_ALIGN_OFF || m_mode == M_REST);
      chk_bit("fault", fault, m_mode == M_TRIP);
    end

    if (en === 1'b1 && !en_prev) begin en_rise = cyc; fe_at_rise = fe; n_bursts++; end
    if (en === 1'b0 && en_prev)  begin en_fall = cyc; fe_at_fall = fe; end
    if (busy === 1'b1 && !busy_prev) busy_rise = cyc;
    if (fault === 1'b1 && !fault_prev) fault_rise = cyc;
    if (fault === 1'b0 && fault_prev)  fault_fall = cyc;
    if (ocd && !ocd_prev_s) ocd_first = cyc;
    if (ocd) ocd_last = cyc;
    ocd_prev_s = ocd;
    en_prev = (en === 1'b1); busy_prev = (busy === 1'b1); fault_prev = (fault === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bounded wait for an output level: 0=en, 1=busy, 2=fault
  task automatic wait_lvl(input int which, input logic lvl, input int maxc, input string nm);
    int k = 0;
    logic v;
    forever begin
      @(negedge clk);
      v = (which == 0) ? en : (which == 1) ? busy : fault;
      if (v === lvl || k >= maxc) break;
      k++;
    end
    chk_bit(nm, v, lvl);
  endtask

  initial begin
    int b0, tlen;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk_bit("reset_en", en, 1'b0);
    chk_bit("reset_busy", busy, 1'b0);
    chk_bit("reset_fault", fault, 1'b0);
    tick(5);

    // Aligned burst: trig high for 30 cycles
    b0 = n_bursts;
    trig = 1'b1; tick(30); trig = 1'b0;
    wait_lvl(0, 1'b0, 30, "aligned_fall_timeout");
    chk_int("aligned_rise_latency", en_rise - busy_rise, 1, 8);
    chk_int("aligned_rise_on_gen_fe", int'(fe_at_rise), 1, 1);
    chk_int("aligned_fall_on_gen_fe", int'(fe_at_fall), 1, 1);
    chk_int("aligned_high_time", en_fall - en_rise, 22, 38);
    tick(101);
    chk_int("aligned_single_burst", n_bursts - b0, 1, 1);
    wait_lvl(1, 1'b0, 50, "aligned_idle_timeout");

    // On-time limit: trig held for 500 cycles
    b0 = n_bursts;
    trig = 1'b1; tick(500);
    chk_int("onmax_high_time", en_fall - en_rise, ONMAX + 1, ONMAX + 8);
    chk_int("onmax_no_rearm", n_bursts - b0, 1, 1);
    trig = 1'b0;
    wait_lvl(1, 1'b0, 200, "onmax_idle_timeout");

    // gen absent: both alignments run to timeout
    gen_on = 1'b0; tick(5);
    trig = 1'b1; tick(3); trig = 1'b0;
    wait_lvl(0, 1'b1, 20, "noget_rise_timeout");
    wait_lvl(0, 1'b0, 20, "nogen_fall_timeout");
    chk_int("nogen_rise_after_start", en_rise - busy_rise, ALIGN, ALIGN);
    chk_int("nogen_high_time", en_fall - en_rise, ALIGN + 1, ALIGN + 1);
    wait_lvl(1, 1'b0, 200, "nogen_idle_timeout");

    // Holdoff: edge 20 cycles after en falls is ignored, edge at 120 is taken
    gen_on = 1'b1; tick(3);
    trig = 1'b1;
    wait_lvl(0, 1'b1, 20, "holdoff_rise_timeout");
    tick(4); trig = 1'b0;
    wait_lvl(0, 1'b0, 20, "holdoff_fall_timeout");
    b0 = n_bursts;
    tick(19); trig = 1'b1; tick(5); trig = 1'b0;
    tick(95);
    chk_int("holdoff_edge_ignored", n_bursts - b0, 0, 0);
    trig = 1'b1;
    wait_lvl(0, 1'b1, 20, "holdoff_restart_timeout");
    chk_int("holdoff_restart_burst", n_bursts - b0, 1, 1);
    chk_int("holdoff_restart_time", busy_rise - en_fall, 119, 122);
    tick(10); trig = 1'b0;
    wait_lvl(1, 1'b0, 200, "holdoff_idle_timeout");

    // Overcurrent mid-burst, 3 cycles
    b0 = n_bursts;
    trig = 1'b1;
    wait_lvl(0, 1'b1, 20, "ocd_rise_timeout");
    tick(5); ocd = 1'b1; tick(3); ocd = 1'b0;
    chk_int("ocd_fault_same_edge", fault_rise - ocd_first, 0, 0);
    chk_int("ocd_en_off_same_edge", en_fall - ocd_first, 0, 0);
`ifdef OCD_LATCH_EN
    tick(300);
    chk_bit("ocd_latched_fault", fault, 1'b1);
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    chk_bit("ocd_latched_rst_clear", fault, 1'b0);
`else
    wait_lvl(2, 1'b0, 250, "ocd_cooldown_timeout");
    chk_int("ocd_cooldown_time", fault_fall - ocd_last, COOL, COOL);
`endif
    tick(30);
    chk_int("ocd_no_restart_on_level", n_bursts - b0, 1, 1);

    // Reset released with trig high: no burst until a fresh edge
    rst = 1'b1; tick(2); rst = 1'b0;
    b0 = n_bursts;
    tick(40);
    chk_int("rst_trig_high_no_burst", n_bursts - b0, 0, 0);
    trig = 1'b0; tick(2); trig = 1'b1;
    wait_lvl(0, 1'b1, 20, "rst_fresh_edge_timeout");
    chk_int("rst_fresh_edge_burst", n_bursts - b0, 1, 1);
    // Reset mid-burst drops en on that edge
    tick(3); rst = 1'b1; tick(1);
    chk_bit("rst_midburst_en", en, 1'b0);
    rst = 1'b0; trig = 1'b0; tick(5);

    // Randomized phase
    tlen = 0;
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      if (tlen <= 0) begin
        trig = ~trig;
        tlen = trig ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 200));
      end
      tlen--;
      if (ocd) ocd = ($urandom_range(0, 2) != 0);
      else     ocd = ($urandom_range(0, 399) == 0);
      rst = ($urandom_range(0, 2999) == 0);
`ifdef OCD_LATCH_EN
      if (fault && $urandom_range(0, 99) == 0) rst = 1'b1;
`endif
      if ($urandom_range(0, 499) == 0) gen_on = ~gen_on;
    end
    ocd = 1'b0; rst = 1'b0; trig = 1'b0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
